// File: rtl/wallace_mult_pipe_pkg.sv
// Elaboration-time helpers for the pipelined Wallace-tree multiplier:
// row counts per 3:2 level and placement of the internal pipeline registers.
package mult_pkg;

   localparam int MAX_WIDTH = 32;

   // One 3:2 level turns every full group of three rows into two.
   function automatic int next_rows(input int n);
      return 2 * (n / 3) + n % 3;
   endfunction

   // Level 0 holds WIDTH partial-product rows plus the Baugh-Wooley constant row.
   function automatic int rows_at(input int width, input int level);
      int n;
      n = width + 1;
      for (int l = 0; l < level; l++) n = next_rows(n);
      return n;
   endfunction

   function automatic int reduction_levels(input int width);
      int n;
      int levels;
      n = width + 1;
      levels = 0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (n > 2) begin
            n = next_rows(n);
            levels++;
         end
      end
      return levels;
   endfunction

   // STAGES-1 registers spread evenly over the level inputs; the last stage follows the CPA.
   function automatic bit is_reg_boundary(input int width, input int stages, input int level);
      bit hit;
      hit = 1'b0;
      for (int k = 1; k < stages; k++)
         if ((k * reduction_levels(width)) / stages == level) hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/wallace_mult_pipe_if.sv
// Operand/product handshake bundle of the multiplier; the multiplier is the slave side.
interface wallace_mult_pipe_if #(
   parameter int WIDTH = 8
) ();
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               is_signed;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;

   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/wallace_mult_pipe_csa_row.sv
// Row of 3:2 full-adder cells: three vectors in, sum and left-shifted carry out.
module csa_row #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry
);
   assign sum = x ^ y ^ z;

   // The carry out of the top cell falls off; results are taken modulo 2^WIDTH.
   assign carry = {(x[WIDTH-2:0] & y[WIDTH-2:0]) |
                   (x[WIDTH-2:0] & z[WIDTH-2:0]) |
                   (y[WIDTH-2:0] & z[WIDTH-2:0]), 1'b0};
endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier, signed (Baugh-Wooley) or unsigned per
// transaction, with a valid/ready handshake and a single global stall enable.
module wallace_mult_pipe
   import mult_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input logic               clk,
   input logic               rst_n,
   wallace_mult_pipe_if.slave bus
);
   localparam int P      = 2 * WIDTH;
   localparam int N0     = WIDTH + 1;
   localparam int LEVELS = reduction_levels(WIDTH);

   logic              en;
   logic              fill;
   logic [STAGES-1:0] vld;
   logic [P-1:0]      pp_rows [N0];
   logic [P-1:0]      cpa_sum;
   logic [P-1:0]      prod_q;

   // NOTE: every row is cleared before its bits are set, so no path leaves pp_rows unassigned.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         pp_rows[i] = '0;
         for (int j = 0; j < WIDTH; j++)
            pp_rows[i][i+j] = (bus.a[j] & bus.b[i]) ^
                              (bus.is_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
      pp_rows[WIDTH]        = '0;
      pp_rows[WIDTH][WIDTH] = bus.is_signed;
      pp_rows[WIDTH][P-1]   = bus.is_signed;
   end

   // Level lv reduces the rows of level lv-1; its inputs are registered where chosen.
   for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
      localparam int N = rows_at(WIDTH, lv);
      logic [P-1:0] src  [N];
      logic [P-1:0] rows [N];

      if (lv == 0) begin : g_pp
         assign src = pp_rows;
      end else begin : g_csa
         localparam int NP = rows_at(WIDTH, lv - 1);
         localparam int G  = NP / 3;
         for (genvar g = 0; g < G; g++) begin : g_row
            csa_row #(.WIDTH(P)) u_csa (
               .x     (g_lvl[lv-1].rows[3*g]),
               .y     (g_lvl[lv-1].rows[3*g+1]),
               .z     (g_lvl[lv-1].rows[3*g+2]),
               .sum   (src[2*g]),
               .carry (src[2*g+1])
            );
         end
         for (genvar k = 0; k < NP - 3 * G; k++) begin : g_pass
            assign src[2*G+k] = g_lvl[lv-1].rows[3*G+k];
         end
      end

      if (is_reg_boundary(WIDTH, STAGES, lv)) begin : g_reg
         // NOTE: datapath rows carry no reset; the valid chain alone decides what is meaningful.
         always_ff @(posedge clk) begin
            if (en) rows <= src;
         end
      end else begin : g_comb
         assign rows = src;
      end
   end

   assign cpa_sum = g_lvl[LEVELS].rows[0] + g_lvl[LEVELS].rows[1];

   assign en           = !vld[STAGES-1] || bus.out_ready;
   assign bus.in_ready = en;

   // NOTE: non-blocking updates let every stage shift on the same edge without ordering races.
   always_ff @(posedge clk) begin
      if (!rst_n)  vld <= '0;
      else if (en) vld <= STAGES'({vld, bus.in_valid});
   end

   // Valid entering the output stage: the accept itself when there is no internal register.
   if (STAGES == 1) begin : g_fill_in
      assign fill = bus.in_valid;
   end else begin : g_fill_vld
      assign fill = vld[STAGES-2];
   end

   // Only real data is loaded, so the product bus never picks up unknown tree contents.
   always_ff @(posedge clk) begin
      if (!rst_n)          prod_q <= '0;
      else if (en && fill) prod_q <= cpa_sum;
   end

   assign bus.product   = prod_q;
   assign bus.out_valid = vld[STAGES-1];

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench: directed scenarios on an 8x8/2-stage instance, then randomized
// traffic with backpressure on several width/stage configurations against an arithmetic model.
module tb_wallace_mult_pipe;

   localparam int ND  = 5;
   localparam int NTX = 2000;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wallace_mult_pipe_if #(.WIDTH(8))  m0 ();
   wallace_mult_pipe_if #(.WIDTH(4))  m1 ();
   wallace_mult_pipe_if #(.WIDTH(4))  m2 ();
   wallace_mult_pipe_if #(.WIDTH(16)) m3 ();
   wallace_mult_pipe_if #(.WIDTH(16)) m4 ();

   wallace_mult_pipe #(.WIDTH(8),  .STAGES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(m0));
   wallace_mult_pipe #(.WIDTH(4),  .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));
   wallace_mult_pipe #(.WIDTH(4),  .STAGES(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(m2));
   wallace_mult_pipe #(.WIDTH(16), .STAGES(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(m3));
   wallace_mult_pipe #(.WIDTH(16), .STAGES(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(m4));

   function automatic int cfg_w(input int d);
      case (d)
         0:       return 8;
         1, 2:    return 4;
         default: return 16;
      endcase
   endfunction

   // Reference: interpret operands per mode, multiply, keep the low 2*w bits.
   function automatic logic [31:0] ref_mult(input int w, input logic [15:0] x,
                                            input logic [15:0] y, input logic s);
      longint mask;
      longint xv;
      longint yv;
      longint p;
      mask = (longint'(1) << w) - 1;
      xv   = longint'(x) & mask;
      yv   = longint'(y) & mask;
      if (s && xv[w-1]) xv = xv - (longint'(1) << w);
      if (s && yv[w-1]) yv = yv - (longint'(1) << w);
      p = xv * yv;
      return 32'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   function automatic logic [15:0] rand_operand(input int w);
      logic [15:0] m;
      m = 16'((32'd1 << w) - 1);
      case ($urandom_range(0, 7))
         0:       return 16'd0;
         1:       return m;
         2:       return 16'(32'd1 << (w - 1));
         default: return 16'($urandom) & m;
      endcase
   endfunction

   task automatic drive(input int d, input logic v, input logic [15:0] x,
                        input logic [15:0] y, input logic s, input logic r);
      case (d)
         0: begin m0.in_valid = v; m0.a = x[7:0]; m0.b = y[7:0]; m0.is_signed = s; m0.out_ready = r; end
         1: begin m1.in_valid = v; m1.a = x[3:0]; m1.b = y[3:0]; m1.is_signed = s; m1.out_ready = r; end
         2: begin m2.in_valid = v; m2.a = x[3:0]; m2.b = y[3:0]; m2.is_signed = s; m2.out_ready = r; end
         3: begin m3.in_valid = v; m3.a = x;      m3.b = y;      m3.is_signed = s; m3.out_ready = r; end
         default: begin m4.in_valid = v; m4.a = x; m4.b = y; m4.is_signed = s; m4.out_ready = r; end
      endcase
   endtask

   task automatic sample(input int d, output logic rdy, output logic vld, output logic [31:0] prod);
      case (d)
         0: begin rdy = m0.in_ready; vld = m0.out_valid; prod = 32'(m0.product); end
         1: begin rdy = m1.in_ready; vld = m1.out_valid; prod = 32'(m1.product); end
         2: begin rdy = m2.in_ready; vld = m2.out_valid; prod = 32'(m2.product); end
         3: begin rdy = m3.in_ready; vld = m3.out_valid; prod = m3.product; end
         default: begin rdy = m4.in_ready; vld = m4.out_valid; prod = m4.product; end
      endcase
   endtask

   task automatic test_reset();
      logic rdy, vld;
      logic [31:0] prod;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int d = 0; d < ND; d++) begin
         sample(d, rdy, vld, prod);
         checks++;
         if (vld !== 1'b0 || prod !== 32'd0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset dut%0d: out_valid=%b product=%h in_ready=%b, want 0/0/1", d, vld, prod, rdy);
         end
      end
   endtask

   task automatic test_unsigned_max();
      logic rdy, vld;
      logic [31:0] prod;
      @(negedge clk);
      drive(0, 1'b1, 16'hFF, 16'hFF, 1'b0, 1'b1);
      #1; sample(0, rdy, vld, prod);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL umax in_ready got %b want 1", rdy); end
      @(negedge clk);
      drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      #1; sample(0, rdy, vld, prod);
      checks++;
      if (vld !== 1'b0) begin errors++; $display("FAIL umax early out_valid got %b want 0", vld); end
      @(negedge clk);
      #1; sample(0, rdy, vld, prod);
      checks++;
      if (vld !== 1'b1 || prod !== 32'hFE01) begin
         errors++; $display("FAIL umax product got v=%b %h want v=1 0000fe01", vld, prod);
      end
      @(negedge clk);
      #1; sample(0, rdy, vld, prod);
      checks++;
      if (vld !== 1'b0) begin errors++; $display("FAIL umax duplicate out_valid got %b want 0", vld); end
   endtask

   task automatic test_signed_b2b();
      logic rdy, vld;
      logic [31:0] prod;
      logic [15:0] xa [3];
      logic [15:0] xb [3];
      logic [31:0] ex [3];
      xa = '{16'h80, 16'h80, 16'h03};
      xb = '{16'h80, 16'h7F, 16'hFB};
      ex = '{32'h4000, 32'hC080, 32'hFFF1};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c < 3) drive(0, 1'b1, xa[c], xb[c], 1'b1, 1'b1);
         else       drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
         #1; sample(0, rdy, vld, prod);
         if (c >= 2) begin
            checks++;
            if (vld !== 1'b1 || prod !== ex[c-2]) begin
               errors++; $display("FAIL signed b2b #%0d got v=%b %h want v=1 %h", c - 2, vld, prod, ex[c-2]);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic rdy, vld, r, s, stalled;
      logic [31:0] prod, held;
      logic [15:0] x, y;
      logic [31:0] q [$];
      int sent, got;
      sent = 0; got = 0; stalled = 1'b0; held = '0;
      for (int c = 0; c < 30 && got < 4; c++) begin
         @(negedge clk);
         r = !(c >= 3 && c < 6);
         x = rand_operand(8); y = rand_operand(8); s = 1'($urandom_range(0, 1));
         drive(0, sent < 4, x, y, s, r);
         #1; sample(0, rdy, vld, prod);
         if (stalled) begin
            checks++;
            if (vld !== 1'b1 || prod !== held) begin
               errors++; $display("FAIL stall hold got v=%b %h want v=1 %h", vld, prod, held);
            end
         end
         if (vld && !r) begin
            checks++;
            if (rdy !== 1'b0) begin errors++; $display("FAIL stall in_ready got %b want 0", rdy); end
         end
         if (vld && r) begin
            checks++;
            got++;
            if (q.size() == 0) begin
               errors++; $display("FAIL stall extra product %h", prod);
            end else begin
               if (prod !== q[0]) begin errors++; $display("FAIL stall order got %h want %h", prod, q[0]); end
               void'(q.pop_front());
            end
         end
         if (sent < 4 && rdy) begin
            q.push_back(ref_mult(8, x, y, s));
            sent++;
         end
         stalled = vld && !r;
         held    = prod;
      end
      drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      checks++;
      if (got != 4 || q.size() != 0) begin
         errors++; $display("FAIL stall count got %0d outputs, %0d pending, want 4/0", got, q.size());
      end
   endtask

   task automatic test_mixed_mode();
      logic rdy, vld;
      logic [31:0] prod;
      logic [31:0] ex [2];
      ex = '{32'hFE01, 32'h0001};
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c < 2) drive(0, 1'b1, 16'hFF, 16'hFF, c == 1, 1'b1);
         else       drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
         #1; sample(0, rdy, vld, prod);
         if (c >= 2) begin
            checks++;
            if (vld !== 1'b1 || prod !== ex[c-2]) begin
               errors++; $display("FAIL mixed #%0d got v=%b %h want v=1 %h", c - 2, vld, prod, ex[c-2]);
            end
         end
      end
   endtask

   task automatic test_reset_in_flight();
      logic rdy, vld;
      logic [31:0] prod;
      @(negedge clk); drive(0, 1'b1, 16'h12, 16'h34, 1'b0, 1'b1);
      @(negedge clk); drive(0, 1'b1, 16'h9C, 16'h27, 1'b1, 1'b1);
      @(negedge clk); drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      #1; sample(0, rdy, vld, prod);
      checks++;
      if (vld !== 1'b0 || rdy !== 1'b1) begin
         errors++; $display("FAIL flush first cycle out_valid=%b in_ready=%b want 0/1", vld, rdy);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1; sample(0, rdy, vld, prod);
         checks++;
         if (vld !== 1'b0) begin errors++; $display("FAIL flush emitted %h at cycle %0d", prod, c); end
      end
   endtask

   task automatic test_random();
      for (int d = 0; d < ND; d++) begin
         int w;
         int sent;
         logic rdy, vld, v, r, s, stalled;
         logic [31:0] prod, held;
         logic [15:0] x, y;
         logic [31:0] q [$];
         w = cfg_w(d);
         sent = 0; stalled = 1'b0; held = '0;
         for (int c = 0; c < 4 * NTX && (sent < NTX || q.size() > 0); c++) begin
            @(negedge clk);
            v = (sent < NTX) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            x = rand_operand(w); y = rand_operand(w); s = 1'($urandom_range(0, 1));
            drive(d, v, x, y, s, r);
            #1; sample(d, rdy, vld, prod);
            checks++;
            if (rdy !== (!vld || r)) begin
               errors++; $display("FAIL rand dut%0d in_ready got %b want %b", d, rdy, !vld || r);
            end
            if (stalled) begin
               checks++;
               if (vld !== 1'b1 || prod !== held) begin
                  errors++; $display("FAIL rand dut%0d hold got v=%b %h want v=1 %h", d, vld, prod, held);
               end
            end
            if (vld && r) begin
               checks++;
               if (q.size() == 0) begin
                  errors++; $display("FAIL rand dut%0d extra product %h", d, prod);
               end else begin
                  if (prod !== q[0]) begin
                     errors++; $display("FAIL rand dut%0d product got %h want %h", d, prod, q[0]);
                  end
                  void'(q.pop_front());
               end
            end
            if (v && rdy) begin
               q.push_back(ref_mult(w, x, y, s));
               sent++;
            end
            stalled = vld && !r;
            held    = prod;
         end
         drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
         checks++;
         if (sent != NTX || q.size() != 0) begin
            errors++; $display("FAIL rand dut%0d timeout sent=%0d pending=%0d", d, sent, q.size());
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      test_reset();
      test_unsigned_max();
      test_signed_b2b();
      test_stall();
      test_mixed_mode();
      test_reset_in_flight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
